// File: rtl/sram_1r1w_param.sv
// Single-clock 1R1W synchronous SRAM with per-lane write mask, selectable
// read-during-write result, optional second output register and status flags.
module sram_1r1w_param #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 4,
    parameter int RAM_DEPTH    = 16,
    parameter int WMASK_WIDTH  = 1,
    parameter int RDW_MODE     = 0,
    parameter int READ_LATENCY = 1
) (
    input  logic                   clk0,
    input  logic                   rstb0,
    input  logic                   csb0,
    input  logic [ADDR_WIDTH-1:0]  addr0,
    input  logic [DATA_WIDTH-1:0]  din0,
    input  logic [WMASK_WIDTH-1:0] wmask0,
    input  logic                   csb1,
    input  logic [ADDR_WIDTH-1:0]  addr1,
    output logic [DATA_WIDTH-1:0]  dout1,
    output logic                   dout1_valid,
    output logic                   collision,
    output logic                   oob
);

    localparam int LANE_WIDTH = DATA_WIDTH / WMASK_WIDTH;
    // One extra bit so RAM_DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(RAM_DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];

    logic [DATA_WIDTH-1:0] w_bitmask;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic                  w_collision;

    for (genvar g = 0; g < WMASK_WIDTH; g++) begin : g_lane
        assign w_bitmask[g*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{wmask0[g]}};
    end

    assign w_wr_in_range = ({1'b0, addr0} < DEPTH_W);
    assign w_rd_in_range = ({1'b0, addr1} < DEPTH_W);
    assign w_wr_en       = rstb0 && !csb0 && w_wr_in_range;
    assign w_rd_en       = !csb1;
    assign w_collision   = w_rd_en && !csb0 && w_wr_in_range && (addr0 == addr1);

    assign w_rd_word = w_rd_in_range ? r_mem[addr1] : '0;
    // New-data mode merges enabled write lanes over the stored word.
    assign w_rd_data = (RDW_MODE == 1 && w_collision)
                     ? ((w_rd_word & ~w_bitmask) | (din0 & w_bitmask))
                     : w_rd_word;

    always_ff @(posedge clk0) begin
        if (w_wr_en) begin
            r_mem[addr0] <= (r_mem[addr0] & ~w_bitmask) | (din0 & w_bitmask);
        end
    end

    logic [DATA_WIDTH-1:0] r_s1_data;
    logic                  r_s1_valid;
    logic                  r_s1_coll;
    logic                  r_s1_oob;

    always_ff @(posedge clk0) begin
        if (!rstb0) begin
            r_s1_data  <= '0;
            r_s1_valid <= 1'b0;
            r_s1_coll  <= 1'b0;
            r_s1_oob   <= 1'b0;
        end else begin
            r_s1_valid <= w_rd_en;
            r_s1_coll  <= w_collision;
            r_s1_oob   <= w_rd_en && !w_rd_in_range;
            if (w_rd_en) begin
                r_s1_data <= w_rd_data;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] r_s2_data;
        logic                  r_s2_valid;
        logic                  r_s2_coll;
        logic                  r_s2_oob;

        // Flags in stage 1 are already zero when it holds no valid result.
        always_ff @(posedge clk0) begin
            if (!rstb0) begin
                r_s2_data  <= '0;
                r_s2_valid <= 1'b0;
                r_s2_coll  <= 1'b0;
                r_s2_oob   <= 1'b0;
            end else begin
                r_s2_valid <= r_s1_valid;
                r_s2_coll  <= r_s1_coll;
                r_s2_oob   <= r_s1_oob;
                if (r_s1_valid) begin
                    r_s2_data <= r_s1_data;
                end
            end
        end

        assign dout1       = r_s2_data;
        assign dout1_valid = r_s2_valid;
        assign collision   = r_s2_coll;
        assign oob         = r_s2_oob;
    end else begin : g_lat1
        assign dout1       = r_s1_data;
        assign dout1_valid = r_s1_valid;
        assign collision   = r_s1_coll;
        assign oob         = r_s1_oob;
    end

endmodule

// File: tb/tb_sram_1r1w_param.sv
// Drives two SRAM configurations with shared stimulus and checks each against
// a per-cycle behavioural model of memory contents and read results.
module tb_sram_1r1w_param;

  logic        clk;
  logic        rstb0;
  logic        csb0;
  logic [3:0]  addr0;
  logic [15:0] din0;
  logic [1:0]  wmask0;
  logic        csb1;
  logic [3:0]  addr1;

  logic [15:0] a_dout, b_dout;
  logic        a_v, a_c, a_o, b_v, b_c, b_o;

  int checks = 0;
  int errors = 0;

  // instance 0: depth 16, old-data, latency 1; instance 1: depth 12, new-data, latency 2
  int          depth [2] = '{16, 12};
  int          rdw   [2] = '{0, 1};
  int          lat   [2] = '{1, 2};

  logic [15:0] mem [2][16];
  bit          kn  [2][16];
  logic [15:0] e_d [2];
  bit          e_k [2];
  logic        e_v [2];
  logic        e_c [2];
  logic        e_o [2];
  logic [15:0] p_d [2];
  bit          p_k [2];
  logic        p_v [2];
  logic        p_c [2];
  logic        p_o [2];

  logic [15:0] o_d [2];
  logic        o_v [2];
  logic        o_c [2];
  logic        o_o [2];
  assign o_d[0] = a_dout;
  assign o_d[1] = b_dout;
  assign o_v[0] = a_v;
  assign o_v[1] = b_v;
  assign o_c[0] = a_c;
  assign o_c[1] = b_c;
  assign o_o[0] = a_o;
  assign o_o[1] = b_o;

  sram_1r1w_param #(
    .DATA_WIDTH(16), .ADDR_WIDTH(4), .RAM_DEPTH(16), .WMASK_WIDTH(2),
    .RDW_MODE(0), .READ_LATENCY(1)
  ) u_a (
    .clk0(clk), .rstb0(rstb0), .csb0(csb0), .addr0(addr0), .din0(din0),
    .wmask0(wmask0), .csb1(csb1), .addr1(addr1), .dout1(a_dout),
    .dout1_valid(a_v), .collision(a_c), .oob(a_o)
  );

  sram_1r1w_param #(
    .DATA_WIDTH(16), .ADDR_WIDTH(4), .RAM_DEPTH(12), .WMASK_WIDTH(2),
    .RDW_MODE(1), .READ_LATENCY(2)
  ) u_b (
    .clk0(clk), .rstb0(rstb0), .csb0(csb0), .addr0(addr0), .din0(din0),
    .wmask0(wmask0), .csb1(csb1), .addr1(addr1), .dout1(b_dout),
    .dout1_valid(b_v), .collision(b_c), .oob(b_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Apply one cycle of inputs, advance the model across the edge, then step
  // past the edge so outputs can be sampled.
  task automatic drive_edge(input logic rst, input logic cs0, input logic [3:0] a0,
                            input logic [15:0] d0, input logic [1:0] m0,
                            input logic cs1, input logic [3:0] a1);
    logic [15:0] bm, rd, sd;
    logic        rv, rc, ro, sv, sc, so;
    bit          rk, sk;
    rstb0 = rst; csb0 = cs0; addr0 = a0; din0 = d0; wmask0 = m0; csb1 = cs1; addr1 = a1;
    bm = {{8{m0[1]}}, {8{m0[0]}}};
    for (int n = 0; n < 2; n++) begin
      if (!rst) begin
        e_d[n] = '0; e_k[n] = 1; e_v[n] = 0; e_c[n] = 0; e_o[n] = 0;
        p_v[n] = 0; p_c[n] = 0; p_o[n] = 0;
      end else begin
        rv = !cs1;
        ro = rv && (int'(a1) >= depth[n]);
        rc = rv && !cs0 && (a0 == a1) && (int'(a0) < depth[n]);
        if (int'(a1) >= depth[n]) begin
          rd = '0; rk = 1;
        end else begin
          rd = mem[n][a1]; rk = kn[n][a1];
        end
        if (rc && rdw[n] == 1) begin
          rd = (rd & ~bm) | (d0 & bm);
          rk = rk || (m0 == 2'b11);
        end
        if (!cs0 && int'(a0) < depth[n]) begin
          mem[n][a0] = (mem[n][a0] & ~bm) | (d0 & bm);
          kn[n][a0] = kn[n][a0] || (m0 == 2'b11);
        end
        if (lat[n] == 1) begin
          sv = rv; sc = rc; so = ro; sd = rd; sk = rk;
        end else begin
          sv = p_v[n]; sc = p_c[n]; so = p_o[n]; sd = p_d[n]; sk = p_k[n];
          p_v[n] = rv; p_c[n] = rc; p_o[n] = ro; p_d[n] = rd; p_k[n] = rk;
        end
        e_v[n] = sv;
        e_c[n] = sv && sc;
        e_o[n] = sv && so;
        if (sv) begin
          e_d[n] = sd; e_k[n] = sk;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 5; c++) begin
      if (c < 3) drive_edge(1'b0, 1'b0, 4'd3, 16'hDEAD, 2'b11, 1'b0, 4'd3);
      else if (c == 3) drive_edge(1'b1, 1'b1, 4'd0, 16'h0, 2'b00, 1'b0, 4'd3);
      else drive_edge(1'b1, 1'b1, 4'd0, 16'h0, 2'b00, 1'b1, 4'd0);
      for (int n = 0; n < 2; n++) begin
        checks++;
        if (o_v[n] !== e_v[n] || o_c[n] !== e_c[n] || o_o[n] !== e_o[n] ||
            (e_k[n] && o_d[n] !== e_d[n])) begin
          errors++;
          $display("FAIL reset inst%0d cyc%0d: got v=%b c=%b o=%b d=%h exp v=%b c=%b o=%b d=%h",
                   n, c, o_v[n], o_c[n], o_o[n], o_d[n], e_v[n], e_c[n], e_o[n], e_d[n]);
        end
      end
    end
  endtask

  task automatic test_fill_readback();
    int pulses;
    pulses = 0;
    for (int c = 0; c < 34; c++) begin
      if (c < 16) drive_edge(1'b1, 1'b0, 4'(c), 16'hA0 + 16'(c), 2'b11, 1'b1, 4'd0);
      else if (c < 32) drive_edge(1'b1, 1'b1, 4'd0, 16'h0, 2'b00, 1'b0, 4'(c - 16));
      else drive_edge(1'b1, 1'b1, 4'd0, 16'h0, 2'b00, 1'b1, 4'd0);
      if (a_v === 1'b1) pulses++;
      for (int n = 0; n < 2; n++) begin
        checks++;
        if (o_v[n] !== e_v[n] || o_c[n] !== e_c[n] || o_o[n] !== e_o[n] ||
            (e_k[n] && o_d[n] !== e_d[n])) begin
          errors++;
          $display("FAIL fill_readback inst%0d cyc%0d: got v=%b c=%b o=%b d=%h exp v=%b c=%b o=%b d=%h",
                   n, c, o_v[n], o_c[n], o_o[n], o_d[n], e_v[n], e_c[n], e_o[n], e_d[n]);
        end
      end
    end
    checks++;
    if (pulses !== 16) begin
      errors++;
      $display("FAIL fill_pulses: got %0d exp 16", pulses);
    end
  endtask

  task automatic test_masked_write();
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: drive_edge(1'b1, 1'b0, 4'd5, 16'h1234, 2'b11, 1'b1, 4'd0);
        1: drive_edge(1'b1, 1'b0, 4'd5, 16'hABCD, 2'b01, 1'b1, 4'd0);
        2: drive_edge(1'b1, 1'b1, 4'd0, 16'h0, 2'b00, 1'b0, 4'd5);
        default: drive_edge(1'b1, 1'b1, 4'd0, 16'h0, 2'b00, 1'b1, 4'd0);
      endcase
      for (int n = 0; n < 2; n++) begin
        checks++;
        if (o_v[n] !== e_v[n] || o_c[n] !== e_c[n] || o_o[n] !== e_o[n] ||
            (e_k[n] && o_d[n] !== e_d[n])) begin
          errors++;
          $display("FAIL masked inst%0d cyc%0d: got v=%b c=%b o=%b d=%h exp v=%b c=%b o=%b d=%h",
                   n, c, o_v[n], o_c[n], o_o[n], o_d[n], e_v[n], e_c[n], e_o[n], e_d[n]);
        end
      end
      if (c == 2) begin
        checks++;
        if (a_dout !== 16'h12CD || a_v !== 1'b1) begin
          errors++;
          $display("FAIL masked_lit_a: got d=%h v=%b exp d=12cd v=1", a_dout, a_v);
        end
      end
      if (c == 3) begin
        checks++;
        if (b_dout !== 16'h12CD || b_v !== 1'b1) begin
          errors++;
          $display("FAIL masked_lit_b: got d=%h v=%b exp d=12cd v=1", b_dout, b_v);
        end
      end
    end
  endtask

  task automatic test_collision();
    for (int c = 0; c < 7; c++) begin
      case (c)
        0: drive_edge(1'b1, 1'b0, 4'd2, 16'h5555, 2'b11, 1'b1, 4'd0);
        1: drive_edge(1'b1, 1'b0, 4'd2, 16'hAAAA, 2'b11, 1'b0, 4'd2);
        2: drive_edge(1'b1, 1'b1, 4'd0, 16'h0, 2'b00, 1'b0, 4'd2);
        3: drive_edge(1'b1, 1'b0, 4'd2, 16'h5555, 2'b11, 1'b1, 4'd0);
        4: drive_edge(1'b1, 1'b0, 4'd2, 16'hAAAA, 2'b10, 1'b0, 4'd2);
        default: drive_edge(1'b1, 1'b1, 4'd0, 16'h0, 2'b00, 1'b1, 4'd0);
      endcase
      for (int n = 0; n < 2; n++) begin
        checks++;
        if (o_v[n] !== e_v[n] || o_c[n] !== e_c[n] || o_o[n] !== e_o[n] ||
            (e_k[n] && o_d[n] !== e_d[n])) begin
          errors++;
          $display("FAIL collision inst%0d cyc%0d: got v=%b c=%b o=%b d=%h exp v=%b c=%b o=%b d=%h",
                   n, c, o_v[n], o_c[n], o_o[n], o_d[n], e_v[n], e_c[n], e_o[n], e_d[n]);
        end
      end
      if (c == 1) begin
        checks++;
        if (a_dout !== 16'h5555 || a_c !== 1'b1) begin
          errors++;
          $display("FAIL coll_old_a: got d=%h c=%b exp d=5555 c=1", a_dout, a_c);
        end
      end
      if (c == 2) begin
        checks++;
        if (a_dout !== 16'hAAAA || a_c !== 1'b0) begin
          errors++;
          $display("FAIL coll_after_a: got d=%h c=%b exp d=aaaa c=0", a_dout, a_c);
        end
      end
      if (c == 5) begin
        checks++;
        if (b_dout !== 16'hAA55 || b_c !== 1'b1) begin
          errors++;
          $display("FAIL coll_new_b: got d=%h c=%b exp d=aa55 c=1", b_dout, b_c);
        end
      end
    end
  endtask

  task automatic test_oob();
    for (int c = 0; c < 16; c++) begin
      if (c == 0) drive_edge(1'b1, 1'b0, 4'd13, 16'h00FF, 2'b11, 1'b1, 4'd0);
      else if (c == 1) drive_edge(1'b1, 1'b1, 4'd0, 16'h0, 2'b00, 1'b0, 4'd13);
      else if (c < 14) drive_edge(1'b1, 1'b1, 4'd0, 16'h0, 2'b00, 1'b0, 4'(c - 2));
      else drive_edge(1'b1, 1'b1, 4'd0, 16'h0, 2'b00, 1'b1, 4'd0);
      for (int n = 0; n < 2; n++) begin
        checks++;
        if (o_v[n] !== e_v[n] || o_c[n] !== e_c[n] || o_o[n] !== e_o[n] ||
            (e_k[n] && o_d[n] !== e_d[n])) begin
          errors++;
          $display("FAIL oob inst%0d cyc%0d: got v=%b c=%b o=%b d=%h exp v=%b c=%b o=%b d=%h",
                   n, c, o_v[n], o_c[n], o_o[n], o_d[n], e_v[n], e_c[n], e_o[n], e_d[n]);
        end
      end
      if (c == 2) begin
        checks++;
        if (b_dout !== 16'h0000 || b_o !== 1'b1 || b_v !== 1'b1) begin
          errors++;
          $display("FAIL oob_lit_b: got d=%h o=%b v=%b exp d=0000 o=1 v=1", b_dout, b_o, b_v);
        end
      end
    end
  endtask

  task automatic test_reset_midpipe();
    int pulses;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      if (c == 0) drive_edge(1'b1, 1'b1, 4'd0, 16'h0, 2'b00, 1'b0, 4'd4);
      else if (c == 1) drive_edge(1'b0, 1'b1, 4'd0, 16'h0, 2'b00, 1'b1, 4'd0);
      else drive_edge(1'b1, 1'b1, 4'd0, 16'h0, 2'b00, 1'b1, 4'd0);
      if (c >= 1 && b_v === 1'b1) pulses++;
      for (int n = 0; n < 2; n++) begin
        checks++;
        if (o_v[n] !== e_v[n] || o_c[n] !== e_c[n] || o_o[n] !== e_o[n] ||
            (e_k[n] && o_d[n] !== e_d[n])) begin
          errors++;
          $display("FAIL midpipe inst%0d cyc%0d: got v=%b c=%b o=%b d=%h exp v=%b c=%b o=%b d=%h",
                   n, c, o_v[n], o_c[n], o_o[n], o_d[n], e_v[n], e_c[n], e_o[n], e_d[n]);
        end
      end
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL midpipe_pulses_b: got %0d exp 0", pulses);
    end
  endtask

  task automatic test_random();
    logic       rst, cs0, cs1;
    logic [3:0] a0, a1;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 39) != 0);
      cs0 = ($urandom_range(0, 2) == 0);
      cs1 = ($urandom_range(0, 3) == 0);
      a0  = 4'($urandom_range(0, 15));
      a1  = ($urandom_range(0, 3) == 0) ? a0 : 4'($urandom_range(0, 15));
      drive_edge(rst, cs0, a0, 16'($urandom), 2'($urandom_range(0, 3)), cs1, a1);
      for (int n = 0; n < 2; n++) begin
        checks++;
        if (o_v[n] !== e_v[n] || o_c[n] !== e_c[n] || o_o[n] !== e_o[n] ||
            (e_k[n] && o_d[n] !== e_d[n])) begin
          errors++;
          $display("FAIL random inst%0d cyc%0d: got v=%b c=%b o=%b d=%h exp v=%b c=%b o=%b d=%h",
                   n, c, o_v[n], o_c[n], o_o[n], o_d[n], e_v[n], e_c[n], e_o[n], e_d[n]);
        end
      end
    end
  endtask

  initial begin
    rstb0 = 1'b0; csb0 = 1'b1; addr0 = '0; din0 = '0; wmask0 = '0; csb1 = 1'b1; addr1 = '0;
    for (int n = 0; n < 2; n++) begin
      for (int a = 0; a < 16; a++) begin
        mem[n][a] = '0;
        kn[n][a]  = 0;
      end
      e_d[n] = '0; e_k[n] = 0; e_v[n] = 0; e_c[n] = 0; e_o[n] = 0;
      p_d[n] = '0; p_k[n] = 0; p_v[n] = 0; p_c[n] = 0; p_o[n] = 0;
    end
    test_reset();
    test_fill_readback();
    test_masked_write();
    test_collision();
    test_oob();
    test_reset_midpipe();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_1r1w_param.md
# sram_1r1w_param

Parametrised single-clock 1R1W synchronous SRAM block: one write port (port 0) and one read port (port 1) sharing one clock. It generalises the fixed 16x8 macro model with these features:
- configurable width and depth
- per-lane write mask
- selectable read-during-write behaviour
- optional output pipeline stage
- read-valid, collision and out-of-range status

It is the storage element under the team's FIFO and buffer controllers, and is synthesisable as a flop array for small configurations.

## Interface
Parameters:
- DATA_WIDTH, 8, bits per word; must be a multiple of WMASK_WIDTH
- ADDR_WIDTH, 4, address bits
- RAM_DEPTH, 16, number of words; 1 to 2^ADDR_WIDTH
- WMASK_WIDTH, 1, write lanes; lane width is DATA_WIDTH/WMASK_WIDTH
- RDW_MODE, 0, read-during-write to the same address: 0 returns old data, 1 returns new (masked-merged) data
- READ_LATENCY, 1, 1 or 2 cycles from read request to dout1

Ports:
- clk0  input  1  single clock; all activity on rising edge
- rstb0  input  1  reset, synchronous, active-low
- csb0  input  1  write select, active-low
- addr0  input  ADDR_WIDTH  write address
- din0  input  DATA_WIDTH  write data
- wmask0  input  WMASK_WIDTH  lane enables, active-high; bit i covers din0[(i+1)*L-1 : i*L]
- csb1  input  1  read select, active-low
- addr1  input  ADDR_WIDTH  read address
- dout1  output  DATA_WIDTH  read data, registered
- dout1_valid  output  1  dout1 carries a new read result this cycle
- collision  output  1  the result on dout1 was a read-during-write to the same address
- oob  output  1  the result on dout1 came from an out-of-range read address

## Operation
- Memory array is RAM_DEPTH x DATA_WIDTH. Contents are not cleared by reset and power up undefined.
- **Write** occurs when rstb0=1 and csb0=0 at an edge and addr0 < RAM_DEPTH. Only lanes with wmask0[i]=1 update; other lanes keep their contents.
- A write with addr0 >= RAM_DEPTH is dropped silently. A write with wmask0=0 changes nothing.
- **Read** occurs when rstb0=1 and csb1=0 at an edge. The address is sampled at that edge.
- For addr1 >= RAM_DEPTH the result data is all zeros, with oob=1.
- **Same-edge collision:** csb0=0, csb1=0, addr0==addr1, both in range.
  - The result carries collision=1.
  - RDW_MODE=0: data is the pre-write word.
  - RDW_MODE=1: enabled lanes return din0 and other lanes return the stored word.
- An out-of-range address pair never flags collision.
- With no read, dout1 holds its last value and dout1_valid=0. collision and oob are meaningful only while dout1_valid=1 and are 0 otherwise.
- **Reset:** rstb0=0 at an edge has these effects:
  - Any write at that edge is suppressed; memory retains its contents.
  - Pipeline valid bits are cleared and any in-flight read is discarded.
  - dout1=0, dout1_valid=0, collision=0, oob=0.
- Reset values of all outputs are 0.

## Timing
- Write commits at edge N; a read of the same address issued at edge N+1 or later returns the new data.
- READ_LATENCY=1: a read sampled at edge N drives dout1, dout1_valid, collision and oob after edge N, i.e. visible during cycle N+1.
- READ_LATENCY=2: an extra register stage; results are visible during cycle N+2. Stage 2 holds its data when no valid result advances.
- Full throughput: one read and one write per cycle, back-to-back, with no stall.
- dout1_valid is a single-cycle pulse per read; consecutive reads produce consecutive pulses.
- Reset asserted mid-pipeline: reads issued before the reset edge produce no valid pulse afterwards.
- The first read sampled at the first edge with rstb0=1 produces a valid pulse at the normal latency.

## Test plan
- **Reset:** hold rstb0=0 for 3 cycles with csb1=0 -> dout1=0 and dout1_valid=0 throughout; release, read addr 3 -> valid pulse at latency 1.
- **Fill and read back:** write addr k with data 8'hA0+k for k=0..15, then read 0..15 back-to-back -> sixteen consecutive valid pulses, data A0..AF, collision=0.
- **Masked write:** DATA_WIDTH=16, WMASK_WIDTH=2.
  - Write addr 5 = 16'h1234 with mask 2'b11, then write 16'hABCD with mask 2'b01 -> read returns 16'h12CD.
- **Collision, RDW_MODE=0:** addr 2 holds 8'h55; same edge, write 8'hAA and read addr 2 -> dout1=8'h55, collision=1. The next read returns 8'hAA.
- **Collision, RDW_MODE=1, 16/2:** addr 2 holds 16'h5555; same edge, write 16'hAAAA with mask 2'b10 and read addr 2 -> dout1=16'hAA55, collision=1.
- **Out of range and latency 2:** RAM_DEPTH=12, READ_LATENCY=2.
  - Write addr 13 with 8'hFF, then read addr 13 -> dout1=0, oob=1 two cycles later, and no addr 0..11 changes.
  - Assert rstb0=0 one cycle after a read issue -> no valid pulse.
